// File: rtl/axi_lite_uart_regs.sv
// AXI4-Lite register slave bridging a bus master to a UART core (TX push, RX pop, baud limit).
// Optional macro UART_RX_IRQ_EN adds the CTRL register at 0x10 and a registered RX-not-empty irq.
module axi_lite_uart_regs #(
    parameter int unsigned DBITS    = 8,
    parameter logic [15:0] BR_RESET = 16'd651
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [4:0]       s_awaddr,
    input  logic             s_awvalid,
    output logic             s_awready,
    input  logic [31:0]      s_wdata,
    input  logic [3:0]       s_wstrb,
    input  logic             s_wvalid,
    output logic             s_wready,
    output logic [1:0]       s_bresp,
    output logic             s_bvalid,
    input  logic             s_bready,
    input  logic [4:0]       s_araddr,
    input  logic             s_arvalid,
    output logic             s_arready,
    output logic [31:0]      s_rdata,
    output logic [1:0]       s_rresp,
    output logic             s_rvalid,
    input  logic             s_rready,
    output logic             write_uart,
    output logic [DBITS-1:0] write_data,
    output logic             read_uart,
    input  logic [DBITS-1:0] read_data,
    input  logic             rx_empty,
    input  logic             rx_full,
    output logic [15:0]      br_limit_out,
    output logic             irq
);
    localparam logic [4:0] A_TX   = 5'h00;
    localparam logic [4:0] A_RX   = 5'h04;
    localparam logic [4:0] A_STAT = 5'h08;
    localparam logic [4:0] A_BAUD = 5'h0C;
    localparam logic [4:0] A_CTRL = 5'h10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t         w_state, w_next;
    r_state_t         r_state, r_next;
    logic             wr_hs_c, rd_hs_c;
    logic             bvalid_d, rvalid_d, wr_uart_d;
    logic [1:0]       bresp_d, rresp_d;
    logic [31:0]      rdata_d;
    logic [DBITS-1:0] wr_data_d;
    logic [15:0]      br_d;
    logic             unused_bits;
`ifdef UART_RX_IRQ_EN
    logic             ctrl_en, ctrl_en_d;
`endif

    // Handshakes complete in the cycle valid is seen; gating with reset keeps ready low while held.
    assign wr_hs_c   = reset && (w_state == W_IDLE) && s_awvalid && s_wvalid;
    assign rd_hs_c   = reset && (r_state == R_IDLE) && s_arvalid;
    assign s_awready = wr_hs_c;
    assign s_wready  = wr_hs_c;
    assign s_arready = rd_hs_c;
    assign read_uart = rd_hs_c && (s_araddr == A_RX) && !rx_empty;
    assign unused_bits = ^{s_wdata[31:16], s_wstrb[3:2]};

    // Write channel: next state and decoded register updates
    always_comb begin
        w_next    = w_state;
        bvalid_d  = s_bvalid;
        bresp_d   = s_bresp;
        wr_uart_d = 1'b0;
        wr_data_d = write_data;
        br_d      = br_limit_out;
`ifdef UART_RX_IRQ_EN
        ctrl_en_d = ctrl_en;
`endif
        case (w_state)
            W_IDLE: begin
                if (wr_hs_c) begin
                    w_next   = W_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                    case (s_awaddr)
                        A_TX: begin
                            if (s_wstrb[0]) begin
                                wr_uart_d = 1'b1;
                                wr_data_d = s_wdata[DBITS-1:0];
                            end
                        end
                        A_RX, A_STAT: begin
                            bresp_d = RESP_OKAY;
                        end
                        A_BAUD: begin
                            if (s_wstrb[0]) br_d[7:0]  = s_wdata[7:0];
                            if (s_wstrb[1]) br_d[15:8] = s_wdata[15:8];
                        end
`ifdef UART_RX_IRQ_EN
                        A_CTRL: begin
                            if (s_wstrb[0]) ctrl_en_d = s_wdata[0];
                        end
`endif
                        default: bresp_d = RESP_SLVERR;
                    endcase
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_next   = W_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Read channel: next state and registered read mux
    always_comb begin
        r_next   = r_state;
        rvalid_d = s_rvalid;
        rdata_d  = s_rdata;
        rresp_d  = s_rresp;
        case (r_state)
            R_IDLE: begin
                if (rd_hs_c) begin
                    r_next   = R_DATA;
                    rvalid_d = 1'b1;
                    rresp_d  = RESP_OKAY;
                    rdata_d  = 32'h0;
                    case (s_araddr)
                        A_TX:    rdata_d = 32'h0;
                        A_RX:    rdata_d = rx_empty ? 32'h100 : 32'(read_data);
                        A_STAT:  rdata_d = {30'h0, rx_full, rx_empty};
                        A_BAUD:  rdata_d = 32'(br_limit_out);
`ifdef UART_RX_IRQ_EN
                        A_CTRL:  rdata_d = 32'(ctrl_en);
`endif
                        default: rresp_d = RESP_SLVERR;
                    endcase
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    r_next   = R_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            w_state      <= W_IDLE;
            r_state      <= R_IDLE;
            s_bvalid     <= 1'b0;
            s_bresp      <= 2'b00;
            s_rvalid     <= 1'b0;
            s_rdata      <= 32'h0;
            s_rresp      <= 2'b00;
            write_uart   <= 1'b0;
            write_data   <= '0;
            br_limit_out <= BR_RESET;
`ifdef UART_RX_IRQ_EN
            ctrl_en      <= 1'b0;
            irq          <= 1'b0;
`endif
        end else begin
            w_state      <= w_next;
            r_state      <= r_next;
            s_bvalid     <= bvalid_d;
            s_bresp      <= bresp_d;
            s_rvalid     <= rvalid_d;
            s_rdata      <= rdata_d;
            s_rresp      <= rresp_d;
            write_uart   <= wr_uart_d;
            write_data   <= wr_data_d;
            br_limit_out <= br_d;
`ifdef UART_RX_IRQ_EN
            ctrl_en      <= ctrl_en_d;
            irq          <= ctrl_en & ~rx_empty;
`endif
        end
    end

`ifndef UART_RX_IRQ_EN
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_uart_regs.sv
// Self-checking bench for axi_lite_uart_regs: scoreboard of expected read results plus pulse monitors.
module tb_axi_lite_uart_regs;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef UART_RX_IRQ_EN
    localparam logic [1:0] CTRL_RESP = OKAY;
`else
    localparam logic [1:0] CTRL_RESP = SLVERR;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b1;
    logic [4:0]  s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic        write_uart;
    logic [7:0]  write_data;
    logic        read_uart;
    logic [7:0]  read_data = '0;
    logic        rx_empty = 1'b1;
    logic        rx_full = 1'b0;
    logic [15:0] br_limit_out;
    logic        irq;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    logic [7:0]  last_wdata = '0;
    logic [15:0] baud_model = 16'd651;

    axi_lite_uart_regs #(.DBITS(8), .BR_RESET(16'd651)) dut (
        .clk_100MHz(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .write_uart(write_uart), .write_data(write_data), .read_uart(read_uart),
        .read_data(read_data), .rx_empty(rx_empty), .rx_full(rx_full),
        .br_limit_out(br_limit_out), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_uart) begin
            wr_pulses = wr_pulses + 1;
            last_wdata = write_data;
        end
        if (read_uart) rd_pulses = rd_pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Full write transaction with bready=1; ok means bvalid one cycle after handshake then cleared.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output bit ok);
        int n = 0;
        ok = 1'b0;
        resp = 2'b11;
        @(posedge clk); #1;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        #1;
        while (!(s_awready && s_wready) && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (s_awready && s_wready) begin
            @(posedge clk); #1;
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            ok = s_bvalid;
            resp = s_bresp;
            @(posedge clk); #1;
            if (s_bvalid) ok = 1'b0;
        end else begin
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
    endtask

    // Full read transaction with rready=1; ok means rvalid one cycle after handshake then cleared.
    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output bit ok);
        int n = 0;
        ok = 1'b0;
        data = 32'hDEAD_BEEF;
        resp = 2'b11;
        @(posedge clk); #1;
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        #1;
        while (!s_arready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (s_arready) begin
            @(posedge clk); #1;
            s_arvalid = 1'b0;
            ok = s_rvalid;
            data = s_rdata;
            resp = s_rresp;
            @(posedge clk); #1;
            if (s_rvalid) ok = 1'b0;
        end else begin
            s_arvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        int wr0, rd0;
        #2 reset = 1'b0;
        s_awaddr = 5'h00; s_wdata = 32'h41; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = 5'h04; s_arvalid = 1'b1; rx_empty = 1'b0; read_data = 8'h77;
        wr0 = wr_pulses; rd0 = rd_pulses;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, write_uart, read_uart, irq} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=00000000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, write_uart, read_uart, irq});
        end
        checks++;
        if (s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 32'h0 || write_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data bresp=%b rresp=%b rdata=%h wdata=%h required all zero",
                     s_bresp, s_rresp, s_rdata, write_data);
        end
        checks++;
        if (br_limit_out !== 16'd651) begin
            failures++;
            $display("FAIL reset_baud got=%0d required=651", br_limit_out);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_araddr = 5'h0C; rx_empty = 1'b1; s_rready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (s_arready !== 1'b1) begin
            failures++;
            $display("FAIL release_arready got=%b required=1", s_arready);
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h28B || s_rresp !== OKAY) begin
            failures++;
            $display("FAIL release_read rvalid=%b rdata=%h rresp=%b required 1/0000028b/00",
                     s_rvalid, s_rdata, s_rresp);
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wr_pulses != wr0 || rd_pulses != rd0) begin
            failures++;
            $display("FAIL reset_pulses wr=%0d rd=%0d required 0/0", wr_pulses - wr0, rd_pulses - rd0);
        end
    endtask

    task automatic test_reset_regs();
        logic [31:0] d; logic [1:0] r; bit ok; rd_exp_t e;
        rx_empty = 1'b1; rx_full = 1'b0;
        exp_q.push_back('{32'h0000_028B, OKAY});
        axi_read(5'h0C, d, r, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e.data || r !== e.resp) begin
            failures++;
            $display("FAIL read_baud_reset got=%h/%b ok=%0d required=%h/%b", d, r, ok, e.data, e.resp);
        end
        exp_q.push_back('{32'h0000_0001, OKAY});
        axi_read(5'h08, d, r, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e.data || r !== e.resp) begin
            failures++;
            $display("FAIL read_status_empty got=%h/%b ok=%0d required=%h/%b", d, r, ok, e.data, e.resp);
        end
    endtask

    task automatic test_tx();
        logic [1:0] r; bit ok; int wr0;
        wr0 = wr_pulses;
        axi_write(5'h00, 32'h0000_0041, 4'b0001, r, ok);
        repeat (2) @(posedge clk);
        checks++;
        if (!ok || r !== OKAY || wr_pulses != wr0 + 1 || last_wdata !== 8'h41) begin
            failures++;
            $display("FAIL tx_push ok=%0d bresp=%b pulses=%0d data=%h required 1/00/1/41",
                     ok, r, wr_pulses - wr0, last_wdata);
        end
        wr0 = wr_pulses;
        axi_write(5'h00, 32'h0000_0055, 4'b0000, r, ok);
        repeat (2) @(posedge clk);
        checks++;
        if (!ok || r !== OKAY || wr_pulses != wr0) begin
            failures++;
            $display("FAIL tx_nostrb ok=%0d bresp=%b pulses=%0d required 1/00/0", ok, r, wr_pulses - wr0);
        end
    endtask

    task automatic test_rx();
        logic [31:0] d; logic [1:0] r; bit ok; rd_exp_t e; int rd0;
        rx_empty = 1'b0; read_data = 8'h5A;
        rd0 = rd_pulses;
        exp_q.push_back('{32'h0000_005A, OKAY});
        axi_read(5'h04, d, r, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e.data || r !== e.resp || rd_pulses != rd0 + 1) begin
            failures++;
            $display("FAIL rx_pop got=%h/%b ok=%0d pulses=%0d required=%h/%b pulses=1",
                     d, r, ok, rd_pulses - rd0, e.data, e.resp);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_disabled got=%b required=0", irq);
        end
        rx_empty = 1'b1;
        rd0 = rd_pulses;
        exp_q.push_back('{32'h0000_0100, OKAY});
        axi_read(5'h04, d, r, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e.data || r !== e.resp || rd_pulses != rd0) begin
            failures++;
            $display("FAIL rx_empty_read got=%h/%b ok=%0d pulses=%0d required=%h/%b pulses=0",
                     d, r, ok, rd_pulses - rd0, e.data, e.resp);
        end
    endtask

    task automatic test_baud();
        logic [1:0] r; bit ok;
        logic [31:0] wd[3] = '{32'h0000_1234, 32'h0000_0034, 32'h0000_5600};
        logic [3:0]  ws[3] = '{4'b0001, 4'b0011, 4'b0010};
        logic [15:0] want[3] = '{16'h0234, 16'd52, 16'h5634};
        for (int i = 0; i < 3; i++) begin
            if (ws[i][0]) baud_model[7:0]  = wd[i][7:0];
            if (ws[i][1]) baud_model[15:8] = wd[i][15:8];
            axi_write(5'h0C, wd[i], ws[i], r, ok);
            checks++;
            if (!ok || r !== OKAY || br_limit_out !== baud_model || br_limit_out !== want[i]) begin
                failures++;
                $display("FAIL baud_write_%0d ok=%0d bresp=%b got=%h required=%h", i, ok, r, br_limit_out, want[i]);
            end
        end
        baud_model = 16'h0034;
        axi_write(5'h0C, 32'h0000_0034, 4'b0011, r, ok);
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic [1:0] r; bit ok; rd_exp_t e; int wr0, rd0;
        wr0 = wr_pulses; rd0 = rd_pulses;
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, r, ok);
        checks++;
        if (!ok || r !== SLVERR || br_limit_out !== baud_model) begin
            failures++;
            $display("FAIL write_unmapped ok=%0d bresp=%b baud=%h required 1/10/%h", ok, r, br_limit_out, baud_model);
        end
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, r, ok);
        axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, r, ok);
        checks++;
        if (!ok || r !== OKAY || wr_pulses != wr0 || rd_pulses != rd0) begin
            failures++;
            $display("FAIL write_ro ok=%0d bresp=%b pulses=%0d/%0d required 1/00/0/0",
                     ok, r, wr_pulses - wr0, rd_pulses - rd0);
        end
        axi_write(5'h10, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== CTRL_RESP) begin
            failures++;
            $display("FAIL write_ctrl ok=%0d bresp=%b required=%b", ok, r, CTRL_RESP);
        end
        exp_q.push_back('{32'h0, SLVERR});
        axi_read(5'h14, d, r, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || r !== e.resp) begin
            failures++;
            $display("FAIL read_unmapped got=%h/%b ok=%0d required resp=%b", d, r, ok, e.resp);
        end
    endtask

    task automatic test_backpressure();
        int wr0;
        logic [31:0] held;
        wr0 = wr_pulses;
        @(posedge clk); #1;
        s_awaddr = 5'h14; s_wdata = 32'h1; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clk); #1;
        s_awaddr = 5'h00; s_wdata = 32'h99; s_wstrb = 4'h1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_bvalid !== 1'b1 || s_bresp !== SLVERR || s_awready !== 1'b0) begin
                failures++;
                $display("FAIL bhold_%0d bvalid=%b bresp=%b awready=%b required 1/10/0", i, s_bvalid, s_bresp, s_awready);
            end
            @(posedge clk); #1;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_bvalid !== 1'b0 || wr_pulses != wr0) begin
            failures++;
            $display("FAIL bhold_release bvalid=%b pulses=%0d required 0/0", s_bvalid, wr_pulses - wr0);
        end
        held = 32'(baud_model);
        s_araddr = 5'h0C; s_arvalid = 1'b1; s_rready = 1'b0;
        @(posedge clk); #1;
        s_arvalid = 1'b0; s_araddr = 5'h08;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== held || s_rresp !== OKAY) begin
                failures++;
                $display("FAIL rhold_%0d rvalid=%b rdata=%h rresp=%b required 1/%h/00", i, s_rvalid, s_rdata, s_rresp, held);
            end
            @(posedge clk); #1;
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rhold_release rvalid=%b required 0", s_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r; bit ok; rd_exp_t e;
        logic [4:0] addrs[6] = '{5'h08, 5'h0C, 5'h04, 5'h00, 5'h14, 5'h01};
        rx_empty = 1'b1; rx_full = 1'b1;
        exp_q.push_back('{32'h3, OKAY});
        exp_q.push_back('{32'(baud_model), OKAY});
        exp_q.push_back('{32'h100, OKAY});
        exp_q.push_back('{32'h0, OKAY});
        exp_q.push_back('{32'h0, SLVERR});
        exp_q.push_back('{32'h0, SLVERR});
        for (int i = 0; i < 6; i++) begin
            axi_read(addrs[i], d, r, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || r !== e.resp || (e.resp == OKAY && d !== e.data)) begin
                failures++;
                $display("FAIL b2b_read_%h got=%h/%b ok=%0d required=%h/%b", addrs[i], d, r, ok, e.data, e.resp);
            end
        end
        rx_full = 1'b0;
        // Same-cycle BAUD write and read: read must return the previous value.
        @(posedge clk); #1;
        s_awaddr = 5'h0C; s_wdata = 32'h0000_00AA; s_wstrb = 4'b0011; s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = 5'h0C; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
        #1;
        checks++;
        if (s_awready !== 1'b1 || s_arready !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_ready aw=%b ar=%b required 1/1", s_awready, s_arready);
        end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'(baud_model) || s_bvalid !== 1'b1 || br_limit_out !== 16'h00AA) begin
            failures++;
            $display("FAIL same_cycle_baud rdata=%h baud=%h rvalid=%b bvalid=%b required %h/00aa/1/1",
                     s_rdata, br_limit_out, s_rvalid, s_bvalid, 32'(baud_model));
        end
        baud_model = 16'h00AA;
        @(posedge clk); #1;
    endtask

`ifdef UART_RX_IRQ_EN
    task automatic test_irq();
        logic [1:0] r; bit ok;
        rx_empty = 1'b1;
        axi_write(5'h10, 32'h1, 4'b0001, r, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok || r !== OKAY || irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_idle ok=%0d bresp=%b irq=%b required 1/00/0", ok, r, irq);
        end
        rx_empty = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_assert got=%b required=1", irq);
        end
        rx_empty = 1'b1;
        @(posedge clk); #1;
        axi_write(5'h10, 32'h0, 4'b0001, r, ok);
    endtask
`endif

    initial begin
        test_reset();
        test_reset_regs();
        test_tx();
        test_rx();
        test_baud();
        test_unmapped();
        test_backpressure();
        test_back_to_back();
`ifdef UART_RX_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
